// File: rtl/module_seg_scan.sv
// Four-digit common-anode 7-segment scan controller with frame-synchronous
// snapshot commit, per-slot anti-ghosting guard and optional leading-zero blanking.
module module_seg_scan #(
    parameter int REFRESH_DIV  = 27000,
    parameter int GUARD_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] unidades_input,
    input  logic [3:0] decenas_input,
    input  logic [3:0] centenas_input,
    input  logic [3:0] milesimas_input,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [3:0][3:0] disp;
    logic [3:0][3:0] pend;
    logic            pend_full;
    logic            wrap_q;

    logic            slot_end;
    logic            frame_end;
    logic            take;
    logic            commit;
    logic            pend_full_nxt;
    logic [6:0]      seg_p0;
    logic [3:0]      an_p0;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 7'b111_1110;
            4'd1:    enc7 = 7'b011_0000;
            4'd2:    enc7 = 7'b110_1101;
            4'd3:    enc7 = 7'b111_1001;
            4'd4:    enc7 = 7'b011_0011;
            4'd5:    enc7 = 7'b101_1011;
            4'd6:    enc7 = 7'b101_1111;
            4'd7:    enc7 = 7'b111_0000;
            4'd8:    enc7 = 7'b111_1111;
            4'd9:    enc7 = 7'b111_1011;
            default: enc7 = 7'b000_0000;
        endcase
    endfunction

    // A digit is blanked only when every more-significant digit is also zero.
    function automatic logic lz_blank(input logic en, input logic [1:0] i,
                                      input logic [3:0][3:0] v);
        logic z3, z2, z1;
        z3 = (v[3] == 4'd0);
        z2 = z3 && (v[2] == 4'd0);
        z1 = z2 && (v[1] == 4'd0);
        case (i)
            2'd3:    lz_blank = en && z3;
            2'd2:    lz_blank = en && z2;
            2'd1:    lz_blank = en && z1;
            default: lz_blank = 1'b0;
        endcase
    endfunction

    assign slot_end      = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_end     = slot_end && (idx == 2'd3);
    assign take          = load_valid && load_ready;
    assign commit        = frame_end && pend_full;
    assign pend_full_nxt = take || (pend_full && !commit);

    // Stage p0: decode the current slot into pin values
    always_comb begin
        seg_p0 = 7'b000_0000;
        an_p0  = 4'b1111;
        if ((cnt >= CW'(GUARD_CYCLES)) && !lz_blank(blank_lz, idx, disp)) begin
            an_p0  = ~(4'b0001 << idx);
            seg_p0 = enc7(disp[idx]);
        end
    end

    // Stage p1: scan state, handshake buffer and registered pins
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            load_ready <= 1'b0;
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
            seg        <= 7'b000_0000;
            an         <= 4'b1111;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end)
                idx <= idx + 2'd1;
            // Pins lag the scan state by one cycle, so frame_done is delayed to match.
            wrap_q     <= frame_end;
            frame_done <= wrap_q;
            if (commit)
                disp <= pend;
            if (take)
                pend <= {milesimas_input, centenas_input, decenas_input, unidades_input};
            pend_full  <= pend_full_nxt;
            load_ready <= !pend_full_nxt;
            seg        <= seg_p0;
            an         <= an_p0;
        end
    end

endmodule

// File: tb/tb_module_seg_scan.sv
// Directed bench for module_seg_scan with REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_module_seg_scan;

    localparam logic [6:0] S0 = 7'b111_1110, S1 = 7'b011_0000, S2 = 7'b110_1101;
    localparam logic [6:0] S3 = 7'b111_1001, S4 = 7'b011_0011, S5 = 7'b101_1011;
    localparam logic [6:0] S7 = 7'b111_0000, S9 = 7'b111_1011, SB = 7'b000_0000;
    localparam logic [3:0] AU = 4'b1110, AT = 4'b1101, AH = 4'b1011, AM = 4'b0111;
    localparam logic [3:0] AX = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] unidades_input = 4'd0, decenas_input = 4'd0;
    logic [3:0] centenas_input = 4'd0, milesimas_input = 4'd0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    module_seg_scan #(.REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .unidades_input(unidades_input), .decenas_input(decenas_input),
        .centenas_input(centenas_input), .milesimas_input(milesimas_input),
        .load_valid(load_valid), .load_ready(load_ready), .blank_lz(blank_lz),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] u, input logic [3:0] d,
                           input logic [3:0] c, input logic [3:0] m);
        unidades_input  = u;
        decenas_input   = d;
        centenas_input  = c;
        milesimas_input = m;
        load_valid      = 1'b1;
        step(1);
        load_valid      = 1'b0;
        unidades_input  = 4'd8;
        decenas_input   = 4'd8;
        centenas_input  = 4'd8;
        milesimas_input = 4'd8;
    endtask

    task automatic wait_frame(input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            step(1);
            if (frame_done === 1'b1) found = 1'b1;
        end
        chk({tag, "_frame_timeout"}, {31'd0, found}, 32'd1);
    endtask

    // Called on the frame_done cycle; walks the frame checking guard and drive phases.
    task automatic check_frame(input string tag, input logic [3:0][6:0] segs,
                               input logic [3:0][3:0] ans);
        int cur;
        chk({tag, "_fd"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_g0_an"}, {28'd0, an}, {28'd0, AX});
        chk({tag, "_g0_seg"}, {25'd0, seg}, 32'd0);
        step(1);
        cur = 1;
        chk({tag, "_fd_pulse"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_g1_an"}, {28'd0, an}, {28'd0, AX});
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                step(8 * s + 1 - cur);
                cur = 8 * s + 1;
                chk($sformatf("%s_s%0d_guard_an", tag, s), {28'd0, an}, {28'd0, AX});
                chk($sformatf("%s_s%0d_guard_seg", tag, s), {25'd0, seg}, 32'd0);
            end
            step(1);
            cur++;
            chk($sformatf("%s_s%0d_an", tag, s), {28'd0, an}, {28'd0, ans[s]});
            chk($sformatf("%s_s%0d_seg", tag, s), {25'd0, seg}, {25'd0, segs[s]});
            step(5);
            cur += 5;
            chk($sformatf("%s_s%0d_an_end", tag, s), {28'd0, an}, {28'd0, ans[s]});
            chk($sformatf("%s_s%0d_seg_end", tag, s), {25'd0, seg}, {25'd0, segs[s]});
        end
    endtask

    initial begin
        int n;
        // Reset held for three cycles
        step(3);
        chk("rst_an", {28'd0, an}, {28'd0, AX});
        chk("rst_seg", {25'd0, seg}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        step(1);
        chk("rel_ready", {31'd0, load_ready}, 32'd1);

        // Single load of 1234, then a back-pressured 9999
        do_load(4'd4, 4'd3, 4'd2, 4'd1);
        chk("load_ready_drop", {31'd0, load_ready}, 32'd0);
        do_load(4'd9, 4'd9, 4'd9, 4'd9);
        chk("bp_ready", {31'd0, load_ready}, 32'd0);
        wait_frame("f1234");
        check_frame("f1234", {S1, S2, S3, S4}, {AM, AH, AT, AU});
        chk("ready_after_commit", {31'd0, load_ready}, 32'd1);
        wait_frame("f1234b");
        check_frame("f1234b", {S1, S2, S3, S4}, {AM, AH, AT, AU});
        do_load(4'd9, 4'd9, 4'd9, 4'd9);
        wait_frame("f9999");
        check_frame("f9999", {S9, S9, S9, S9}, {AM, AH, AT, AU});

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(4'd5, 4'd0, 4'd0, 4'd0);
        wait_frame("lz0005");
        check_frame("lz0005", {SB, SB, SB, S5}, {AX, AX, AX, AU});
        do_load(4'd5, 4'd0, 4'd1, 4'd0);
        wait_frame("lz0105");
        check_frame("lz0105", {SB, S1, S0, S5}, {AX, AH, AT, AU});
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        wait_frame("lz0000");
        check_frame("lz0000", {SB, SB, SB, S0}, {AX, AX, AX, AU});
        blank_lz = 1'b0;
        wait_frame("nolz0000");
        check_frame("nolz0000", {S0, S0, S0, S0}, {AM, AH, AT, AU});

        // Invalid BCD in the tens position
        do_load(4'd7, 4'hA, 4'd0, 4'd0);
        wait_frame("inv");
        check_frame("inv", {S0, S0, SB, S7}, {AM, AH, AT, AU});

        // Reset during the hundreds slot with a pending snapshot
        do_load(4'd1, 4'd1, 4'd1, 4'd1);
        step(19);
        chk("pre_rst_an", {28'd0, an}, {28'd0, AH});
        chk("pre_rst_seg", {25'd0, seg}, {25'd0, S0});
        rst = 1'b1;
        step(1);
        chk("mid_rst_an", {28'd0, an}, {28'd0, AX});
        chk("mid_rst_seg", {25'd0, seg}, 32'd0);
        chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        chk("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            n = k;
            if (k == 1) chk("post_rst_ready", {31'd0, load_ready}, 32'd1);
            if (k == 3) begin
                chk("post_rst_u_an", {28'd0, an}, {28'd0, AU});
                chk("post_rst_u_seg", {25'd0, seg}, {25'd0, S0});
            end
            if (frame_done === 1'b1) break;
        end
        chk("post_rst_fd_latency", n, 32'd33);
        check_frame("post_rst", {S0, S0, S0, S0}, {AM, AH, AT, AU});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
